// File: rtl/axi_pkg.sv
// Shared AXI-Stream helpers: field-width function and the packet source state encoding.
package axi_pkg;

  typedef enum logic [1:0] {
    INIT_WAIT = 2'd0,
    IDLE      = 2'd1,
    SEND      = 2'd2
  } state_e;

  // Bits needed to represent v itself (not v-1), so a length field can hold its maximum.
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    int unsigned t;
    r = 0;
    t = v;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_m_pkt_src.sv
// AXI4-Stream master packet source: on start, emits pkt_len words of data_base + index,
// with TLAST on the final word and a one-cycle done pulse after the last handshake.
module axis_m_pkt_src
  import axi_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M_START_COUNT      = 32,
  parameter int unsigned MAX_PKT_WORDS        = 8,
  parameter int unsigned LEN_W                = clogb2(MAX_PKT_WORDS)
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic                                start,
  input  logic [LEN_W-1:0]                    pkt_len,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     data_base,
  output logic                                busy,
  output logic                                done,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int unsigned W = C_M_AXIS_TDATA_WIDTH;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_PKT_WORDS);

  state_e             state_q, state_d;
  logic [31:0]        init_cnt_q, init_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic [W-1:0]       tdata_q, tdata_d;
  logic               done_q, done_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    done_d     = 1'b0;

    unique case (state_q)
      INIT_WAIT: begin
        if (init_cnt_q == C_M_START_COUNT) begin
          state_d = IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 32'd1;
        end
      end
      IDLE: begin
        if (start && (pkt_len != '0)) begin
          len_d    = (pkt_len > MaxLen) ? MaxLen : pkt_len;
          idx_d    = '0;
          tdata_d  = data_base;
          tlast_d  = (len_d == LEN_W'(1));
          tvalid_d = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        // TVALID is always high in SEND, so TREADY alone marks a transfer.
        if (M_AXIS_TREADY) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            tdata_d = tdata_q + W'(1);
            tlast_d = (idx_d == (len_q - LEN_W'(1)));
          end
        end
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= INIT_WAIT;
      init_cnt_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      done_q     <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_axis_m_pkt_src.sv
// Randomized self-checking bench for axis_m_pkt_src against a queue-based packet model.
module tb_axis_m_pkt_src;

  localparam int unsigned W    = 32;
  localparam int unsigned C    = 32;
  localparam int unsigned MAXW = 8;
  localparam int unsigned LW   = 4;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [W-1:0]  data_base = '0;
  logic          tready = 1'b0;
  logic          busy, done, tvalid, tlast;
  logic [W-1:0]  tdata;
  logic [W/8-1:0] tstrb;

  always #5 clk = ~clk;

  axis_m_pkt_src #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .C_M_START_COUNT      (C),
    .MAX_PKT_WORDS        (MAXW)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (arstn),
    .start          (start),
    .pkt_len        (pkt_len),
    .data_base      (data_base),
    .busy           (busy),
    .done           (done),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  // Reference model: remaining words of the current packet, edges since reset release.
  word_t exp_q[$];
  int    edges_seen = 0;
  bit    exp_done = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit st, input int len, input logic [W-1:0] base,
                            input bit rdy);
    int n;
    word_t w;
    exp_done = 1'b0;
    if (edges_seen <= int'(C)) begin
      // still waiting out the start-up delay; start ignored
    end else if (exp_q.size() != 0) begin
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_done = 1'b1;
      end
    end else if (st && len != 0) begin
      n = (len > int'(MAXW)) ? int'(MAXW) : len;
      for (int i = 0; i < n; i++) begin
        w.data = base + W'(i);
        w.last = (i == n - 1);
        exp_q.push_back(w);
      end
    end
    if (edges_seen <= int'(C)) edges_seen++;
  endtask

  task automatic check_cycle();
    bit pkt_active;
    pkt_active = (exp_q.size() != 0);
    check_eq("busy", busy, (edges_seen <= int'(C)) || pkt_active);
    check_eq("tvalid", tvalid, pkt_active);
    if (pkt_active) begin
      check_eq("tdata", tdata, exp_q[0].data);
      check_eq("tlast", tlast, exp_q[0].last);
    end else begin
      check_eq("tlast_idle", tlast, 0);
    end
    check_eq("done", done, exp_done);
    check_eq("tstrb", tstrb, 4'hF);
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, check after it.
  task automatic step(input bit st, input int len, input logic [W-1:0] base, input bit rdy);
    start     = st;
    pkt_len   = LW'(len);
    data_base = base;
    tready    = rdy;
    model_edge(st, len, base, rdy);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle_steps(input int n, input bit rand_rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, '0, rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1);
  endtask

  // Asserted away from the clock edge so the asynchronous clear is what gets observed.
  task automatic apply_reset_async(input int hold);
    start = 1'b0;
    tready = 1'b0;
    #2 arstn = 1'b0;
    #1;
    check_eq("rst_tvalid", tvalid, 0);
    check_eq("rst_tlast", tlast, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_tdata", tdata, 0);
    check_eq("rst_tstrb", tstrb, 4'hF);
    repeat (hold) @(negedge clk);
    arstn = 1'b1;
    exp_q.delete();
    edges_seen = 0;
    exp_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_idle;
    logic [W-1:0] b;
    @(negedge clk);
    apply_reset_async(3);

    // Start-up delay: start at 5 ignored, start at 40 accepted.
    first_idle = -1;
    for (int s = 0; s < 60; s++) begin
      step((s == 5) || (s == 40), 2, 32'h0000_00A0, 1'b1);
      if (first_idle < 0 && !busy) first_idle = s + 1;
    end
    check_eq("init_edges", 64'(first_idle), 64'(C + 1));

    // Four-word packet at full throughput.
    step(1'b1, 4, 32'h0000_0100, 1'b1);
    idle_steps(7, 1'b0);

    // Stalls: TREADY 1,0,0,1,0,1 then high.
    b = $urandom;
    step(1'b1, 3, b, 1'b1);
    step(1'b0, 0, '0, 1'b1);
    step(1'b0, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1);
    step(1'b0, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1);
    idle_steps(4, 1'b0);

    // Length clamp with data wrap, then a zero-length request.
    step(1'b1, 12, 32'hFFFF_FFFE, 1'b1);
    idle_steps(11, 1'b0);
    step(1'b1, 0, 32'h1234_5678, 1'b1);
    idle_steps(4, 1'b0);

    // start held high: back-to-back packets with one idle cycle between.
    for (int i = 0; i < 20; i++) step(1'b1, 2, 32'h0000_0500, 1'b1);
    idle_steps(3, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 12)), $urandom,
           $urandom_range(0, 9) < 7);
    end
    idle_steps(12, 1'b0);

    // Reset in the middle of a packet.
    step(1'b1, 8, 32'h0000_0A00, 1'b1);
    step(1'b0, 0, '0, 1'b1);
    step(1'b0, 0, '0, 1'b0);
    check_eq("pre_rst_tvalid", tvalid, 1);
    apply_reset_async(2);
    idle_steps(40, 1'b1);
    step(1'b1, 5, $urandom, 1'b1);
    idle_steps(10, 1'b1);
    idle_steps(8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
